// File: rtl/tdm_demux18.sv
// Time-division 1:8 demultiplexer: steers sync-framed WIDTH-bit slots into eight lanes
// and presents each completed frame as one registered parallel word.
module tdm_demux18 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               sync_in,
    output logic [8*WIDTH-1:0] dout,
    output logic               dout_valid,
    output logic [2:0]         slot,
    output logic               busy,
    output logic               frame_err
);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shadow_q [8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            slot       <= 3'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (din_valid) begin
                unique case (state_q)
                    StIdle: begin
                        if (sync_in) begin
                            shadow_q[0] <= din;
                            slot        <= 3'd1;
                            state_q     <= StCollect;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    StCollect: begin
                        if (sync_in) begin
                            // Early sync: restart the frame from this beat.
                            frame_err   <= 1'b1;
                            shadow_q[0] <= din;
                            slot        <= 3'd1;
                        end else begin
                            shadow_q[slot] <= din;
                            if (slot == 3'd7) begin
                                for (int k = 0; k < 7; k++) begin
                                    dout[k*WIDTH +: WIDTH] <= shadow_q[k];
                                end
                                dout[7*WIDTH +: WIDTH] <= din;
                                dout_valid             <= 1'b1;
                                slot                   <= 3'd0;
                                state_q                <= StIdle;
                            end else begin
                                slot <= slot + 3'd1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy = (state_q == StCollect);

endmodule

// File: tb/tb_tdm_demux18.sv
// Directed self-checking bench for tdm_demux18 at WIDTH=4; single-bit cases use 0/1 nibbles.
module tb_tdm_demux18;

    localparam int unsigned WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [WIDTH-1:0]   din = '0;
    logic               din_valid = 1'b0;
    logic               sync_in = 1'b0;
    logic [8*WIDTH-1:0] dout;
    logic               dout_valid;
    logic [2:0]         slot;
    logic               busy;
    logic               frame_err;

    int tests = 0;
    int fails = 0;
    int vcount = 0;
    int ecount = 0;

    tdm_demux18 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync_in    (sync_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1ns after the edge and tally pulses.
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d);
        din_valid = v;
        sync_in   = s;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync_in   = 1'b0;
        if (dout_valid) vcount++;
        if (frame_err) ecount++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 4'h9);
        rst = 1'b0;
        vcount = 0;
        ecount = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (dout !== 32'h0) begin fails++; $display("FAIL reset_dout got %h want %h", dout, 32'h0); end
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_dv got %b want 0", dout_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (slot !== 3'd0) begin fails++; $display("FAIL reset_slot got %0d want 0", slot); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    endtask

    task automatic test_basic();
        logic [3:0] bits [8];
        bits = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
        do_reset();
        for (int k = 0; k < 7; k++) step(1'b1, k == 0, bits[k]);
        tests++; if (slot !== 3'd7 || busy !== 1'b1) begin fails++; $display("FAIL basic_mid got slot=%0d busy=%b want 7 1", slot, busy); end
        tests++; if (dout_valid !== 1'b0 || dout !== 32'h0) begin fails++; $display("FAIL basic_early got dv=%b dout=%h want 0 0", dout_valid, dout); end
        step(1'b1, 1'b0, bits[7]);
        tests++; if (dout !== 32'h0100_1101) begin fails++; $display("FAIL basic_dout got %h want %h", dout, 32'h0100_1101); end
        tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL basic_dv got %b want 1", dout_valid); end
        tests++; if (busy !== 1'b0 || slot !== 3'd0) begin fails++; $display("FAIL basic_end got busy=%b slot=%0d want 0 0", busy, slot); end
        step(1'b0, 1'b0, 4'h0);
        tests++; if (dout_valid !== 1'b0 || dout !== 32'h0100_1101) begin fails++; $display("FAIL basic_hold got dv=%b dout=%h want 0 01001101", dout_valid, dout); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] gaps;
        gaps = 8'b1011_0101;
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1, k == 0, 4'(k));
        tests++; if (dout !== 32'h7654_3210 || dout_valid !== 1'b1) begin fails++; $display("FAIL b2b_a got dout=%h dv=%b want 76543210 1", dout, dout_valid); end
        for (int k = 0; k < 8; k++) begin
            if (gaps[k]) begin
                step(1'b0, 1'b1, 4'h3);
                step(1'b0, 1'b0, 4'h5);
            end
            step(1'b1, k == 0, 4'(15 - k));
            if (k < 7) begin
                tests++; if (dout !== 32'h7654_3210 || dout_valid !== 1'b0) begin fails++; $display("FAIL b2b_hold%0d got dout=%h dv=%b want 76543210 0", k, dout, dout_valid); end
            end
        end
        tests++; if (dout !== 32'h89AB_CDEF || dout_valid !== 1'b1) begin fails++; $display("FAIL b2b_b got dout=%h dv=%b want 89abcdef 1", dout, dout_valid); end
        tests++; if (vcount !== 2 || ecount !== 0) begin fails++; $display("FAIL b2b_counts got dv=%0d ferr=%0d want 2 0", vcount, ecount); end
    endtask

    task automatic test_early_sync();
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, 4'(k + 1));
        step(1'b1, 1'b1, 4'hA);
        tests++; if (frame_err !== 1'b1 || slot !== 3'd1 || busy !== 1'b1) begin fails++; $display("FAIL early_err got ferr=%b slot=%0d busy=%b want 1 1 1", frame_err, slot, busy); end
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 4'hA);
        tests++; if (dout !== 32'hAAAA_AAAA || dout_valid !== 1'b1) begin fails++; $display("FAIL early_dout got dout=%h dv=%b want aaaaaaaa 1", dout, dout_valid); end
        tests++; if (vcount !== 1 || ecount !== 1) begin fails++; $display("FAIL early_counts got dv=%0d ferr=%0d want 1 1", vcount, ecount); end
    endtask

    task automatic test_no_sync();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4'h5);
            tests++; if (frame_err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL nosync_err%0d got ferr=%b busy=%b want 1 0", k, frame_err, busy); end
        end
        step(1'b0, 1'b0, 4'h0);
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL nosync_clear got %b want 0", frame_err); end
        tests++; if (ecount !== 3 || vcount !== 0 || dout !== 32'h0 || slot !== 3'd0) begin fails++; $display("FAIL nosync_end got ferr=%0d dv=%0d dout=%h slot=%0d want 3 0 0 0", ecount, vcount, dout, slot); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, k == 0, 4'h1);
        rst = 1'b1;
        step(1'b1, 1'b0, 4'h1);
        rst = 1'b0;
        tests++; if (busy !== 1'b0 || slot !== 3'd0 || frame_err !== 1'b0) begin fails++; $display("FAIL rstmid_state got busy=%b slot=%0d ferr=%b want 0 0 0", busy, slot, frame_err); end
        vcount = 0;
        ecount = 0;
        for (int k = 0; k < 8; k++) step(1'b1, k == 0, 4'h1);
        tests++; if (dout !== 32'h1111_1111 || dout_valid !== 1'b1) begin fails++; $display("FAIL rstmid_dout got dout=%h dv=%b want 11111111 1", dout, dout_valid); end
        tests++; if (vcount !== 1 || ecount !== 0) begin fails++; $display("FAIL rstmid_counts got dv=%0d ferr=%0d want 1 0", vcount, ecount); end
    endtask

    task automatic test_ignored_sync();
        do_reset();
        step(1'b0, 1'b1, 4'h7);
        tests++; if (busy !== 1'b0 || slot !== 3'd0 || frame_err !== 1'b0) begin fails++; $display("FAIL ign_idle got busy=%b slot=%0d ferr=%b want 0 0 0", busy, slot, frame_err); end
        for (int k = 0; k < 3; k++) step(1'b1, k == 0, 4'h2);
        step(1'b0, 1'b1, 4'h7);
        step(1'b0, 1'b1, 4'h7);
        tests++; if (busy !== 1'b1 || slot !== 3'd3 || frame_err !== 1'b0) begin fails++; $display("FAIL ign_coll got busy=%b slot=%0d ferr=%b want 1 3 0", busy, slot, frame_err); end
        tests++; if (ecount !== 0 || vcount !== 0) begin fails++; $display("FAIL ign_counts got ferr=%0d dv=%0d want 0 0", ecount, vcount); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_early_sync();
        test_no_sync();
        test_reset_mid();
        test_ignored_sync();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
